// File: rtl/mlp_result_drain_if.sv
// Handshake bundle between the MLP result drain, its upstream result source
// and the AXI-Stream master's write port.
interface mlp_result_drain_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pi_result_data;
    logic                  pi_result_valid;
    logic                  po_result_ready;
    logic [DATA_WIDTH-1:0] po_mlp_data;
    logic                  po_write_to_fifo;
    logic                  pi_wr_fifo_done;

    // master: the drain itself; slave: the surrounding MLP datapath and stream master
    modport master (
        input  pi_result_data,
        input  pi_result_valid,
        input  pi_wr_fifo_done,
        output po_result_ready,
        output po_mlp_data,
        output po_write_to_fifo
    );

    modport slave (
        output pi_result_data,
        output pi_result_valid,
        output pi_wr_fifo_done,
        input  po_result_ready,
        input  po_mlp_data,
        input  po_write_to_fifo
    );
endinterface

// File: rtl/mlp_result_drain.sv
// Buffers MLP output-layer words in a small FIFO and hands them one at a time to
// the AXI-Stream master's write port, counting hand-offs per output frame.
module mlp_result_drain #(
    parameter int  DATA_WIDTH = 32,
    parameter int  FIFO_DEPTH = 8,
    parameter int  FRAME_LEN  = 10,
    localparam int CNT_W      = $clog2(FRAME_LEN + 1)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               pi_clear,
    mlp_result_drain_if.master bus,
    output logic               po_frame_done,
    output logic [CNT_W-1:0]   po_word_count,
    output logic               po_overflow,
    output logic               po_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic [OW-1:0]         occ_nxt;
    state_t                state;
    logic [DATA_WIDTH-1:0] mlp_data_q;
    logic                  write_q;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  done;

    assign flush = ARESET || pi_clear;
    assign done  = bus.pi_wr_fifo_done;
    assign full  = (occ == OW'(FIFO_DEPTH));
    assign empty = (occ == '0);
    // Ready comes from registered occupancy only, so a pop never frees a slot same-cycle.
    assign push  = bus.pi_result_valid && !full;
    assign pop   = (state == IDLE) && !empty;

    assign bus.po_result_ready  = !full;
    assign bus.po_mlp_data      = mlp_data_q;
    assign bus.po_write_to_fifo = write_q;

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + OW'(1);
            2'b01:   occ_nxt = occ - OW'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (push && !flush) begin
            mem[wr_ptr] <= bus.pi_result_data;
        end
    end

    always_ff @(posedge ACLK) begin
        if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            po_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            occ <= occ_nxt;
            if (bus.pi_result_valid && full) po_overflow <= 1'b1;
        end
    end

    // GAP absorbs the level acknowledge so one hand-off is never counted twice.
    always_ff @(posedge ACLK) begin
        if (flush) begin
            state         <= IDLE;
            mlp_data_q    <= '0;
            write_q       <= 1'b0;
            po_frame_done <= 1'b0;
            po_word_count <= '0;
            po_busy       <= 1'b0;
        end else begin
            po_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        mlp_data_q <= mem[rd_ptr];
                        write_q    <= 1'b1;
                        state      <= WRITE;
                        po_busy    <= 1'b1;
                    end else begin
                        po_busy <= (occ_nxt != '0);
                    end
                end
                WRITE: begin
                    po_busy <= 1'b1;
                    if (done) begin
                        write_q <= 1'b0;
                        state   <= GAP;
                        if (po_word_count == CNT_W'(FRAME_LEN - 1)) begin
                            po_word_count <= '0;
                            po_frame_done <= 1'b1;
                        end else begin
                            po_word_count <= po_word_count + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (!done) begin
                        state   <= IDLE;
                        po_busy <= (occ_nxt != '0);
                    end else begin
                        po_busy <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    write_q <= 1'b0;
                    po_busy <= (occ_nxt != '0);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_result_drain.sv
// Self-checking bench for mlp_result_drain: scenario tasks against a queue-based
// model of accepted words, frame counts and sticky overflow.
module tb_mlp_result_drain;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int FLEN  = 10;
    localparam int CW    = $clog2(FLEN + 1);

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          pi_clear = 1'b0;
    logic          po_frame_done;
    logic [CW-1:0] po_word_count;
    logic          po_overflow;
    logic          po_busy;
    logic          ack_auto = 1'b0;
    logic          ack_manual = 1'b0;
    logic          auto_done = 1'b0;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] obs_q [$];
    int            fd_cnt = 0;
    int            fd_at = 0;
    int            stab_err = 0;

    mlp_result_drain_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.pi_wr_fifo_done = ack_auto ? auto_done : ack_manual;

    mlp_result_drain #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .FRAME_LEN (FLEN)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .pi_clear     (pi_clear),
        .bus          (bus.master),
        .po_frame_done(po_frame_done),
        .po_word_count(po_word_count),
        .po_overflow  (po_overflow),
        .po_busy      (po_busy)
    );

    always #5 ACLK = ~ACLK;

    // Records every write request (rising po_write_to_fifo) and watches data stability.
    initial begin : monitor
        logic          prev_w;
        logic [DW-1:0] held;
        prev_w = 1'b0;
        held   = '0;
        forever begin
            @(negedge ACLK);
            if (bus.po_write_to_fifo === 1'b1) begin
                if (!prev_w) begin
                    obs_q.push_back(bus.po_mlp_data);
                    held = bus.po_mlp_data;
                end else if (bus.po_mlp_data !== held) begin
                    stab_err++;
                end
            end
            prev_w = (bus.po_write_to_fifo === 1'b1);
            if (po_frame_done === 1'b1) begin
                fd_cnt++;
                fd_at = obs_q.size();
            end
        end
    end

    // Stream-master model: acknowledge 1-10 cycles after a write request, drop after write falls.
    initial begin : ack_model
        int st;
        int dly;
        st  = 0;
        dly = 0;
        forever begin
            @(negedge ACLK);
            if (!ack_auto) begin
                auto_done = 1'b0;
                st = 0;
            end else begin
                case (st)
                    0: if (bus.po_write_to_fifo === 1'b1) begin
                        dly = int'($urandom_range(0, 9));
                        st  = 1;
                    end
                    1: if (dly == 0) begin
                        auto_done = 1'b1;
                        st = 2;
                    end else begin
                        dly--;
                    end
                    2: if (bus.po_write_to_fifo !== 1'b1) begin
                        auto_done = 1'b0;
                        st = 0;
                    end
                    default: st = 0;
                endcase
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic do_clear();
        bus.pi_result_valid = 1'b0;
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        pi_clear   = 1'b1;
        tick();
        pi_clear   = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int base, input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if ((obs_q.size() - base) >= n && po_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [40:0] got;
        bus.pi_result_valid = 1'b1;
        bus.pi_result_data  = 32'hDEAD_BEEF;
        ARESET = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {bus.po_write_to_fifo, po_frame_done, po_overflow, po_busy,
                   bus.po_result_ready, po_word_count, bus.po_mlp_data};
            n_cmp++;
            if (got !== {5'b00001, 4'd0, 32'd0}) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", c, got, {5'b00001, 4'd0, 32'd0});
            end
        end
        ARESET = 1'b0;
        bus.pi_result_valid = 1'b0;
        tick();
        n_cmp++;
        if (po_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_nothing_pushed: busy got %b want 0", po_busy);
        end
        bus.pi_result_valid = 1'b1;
        bus.pi_result_data  = 32'hA5A5_0001;
        tick();
        bus.pi_result_valid = 1'b0;
        n_cmp++;
        if ({bus.po_write_to_fifo, po_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL latency_push_edge: write,busy got %b want 01", {bus.po_write_to_fifo, po_busy});
        end
        tick();
        n_cmp++;
        if ({bus.po_write_to_fifo, bus.po_mlp_data} !== {1'b1, 32'hA5A5_0001}) begin
            n_bad++;
            $display("FAIL latency_next_edge: write,data got %b,%h want 1,a5a50001",
                     bus.po_write_to_fifo, bus.po_mlp_data);
        end
    endtask

    task automatic test_burst();
        int base, fdb, stb, i, guard;
        bit v, acc, ok;
        do_clear();
        ack_auto = 1'b1;
        base = obs_q.size(); fdb = fd_cnt; stb = stab_err;
        i = 0; guard = 0;
        while (i < 10 && guard < 1000) begin
            v = ($urandom_range(0, 3) != 0);
            bus.pi_result_valid = v;
            bus.pi_result_data  = 32'h100 + i;
            acc = v && bus.po_result_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        bus.pi_result_valid = 1'b0;
        wait_idle(base, 10, ok);
        n_cmp++;
        if (!ok || (obs_q.size() - base) != 10) begin
            n_bad++;
            $display("FAIL burst_count: got %0d writes (done=%0b) want 10", obs_q.size() - base, ok);
        end
        for (int k = 0; k < 10 && (base + k) < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[base + k] !== DW'(32'h100 + k)) begin
                n_bad++;
                $display("FAIL burst_order[%0d]: got %h want %h", k, obs_q[base + k], 32'h100 + k);
            end
        end
        n_cmp++;
        if ((fd_cnt - fdb) != 1 || (fd_at - base) != 10) begin
            n_bad++;
            $display("FAIL burst_frame_done: got %0d pulses after %0d words want 1 after 10",
                     fd_cnt - fdb, fd_at - base);
        end
        n_cmp++;
        if (po_word_count !== CW'(0) || stab_err != stb) begin
            n_bad++;
            $display("FAIL burst_count_stable: got count %0d unstable %0d want 0 and 0",
                     po_word_count, stab_err - stb);
        end
    endtask

    task automatic test_fill_overflow();
        int base, acc, drop;
        bit ok;
        do_clear();
        base = obs_q.size(); acc = 0; drop = 0;
        for (int k = 0; k < 12; k++) begin
            bus.pi_result_valid = 1'b1;
            bus.pi_result_data  = 32'h200 + k;
            if (bus.po_result_ready) acc++; else drop++;
            tick();
        end
        bus.pi_result_valid = 1'b0;
        n_cmp++;
        if (acc != DEPTH + 1 || drop != 3) begin
            n_bad++;
            $display("FAIL fill_accept: got %0d accepted %0d dropped want 9 and 3", acc, drop);
        end
        n_cmp++;
        if ({bus.po_result_ready, po_overflow} !== 2'b01) begin
            n_bad++;
            $display("FAIL fill_flags: ready,overflow got %b want 01", {bus.po_result_ready, po_overflow});
        end
        ack_auto = 1'b1;
        wait_idle(base, DEPTH + 1, ok);
        repeat (20) tick();
        n_cmp++;
        if (!ok || (obs_q.size() - base) != DEPTH + 1) begin
            n_bad++;
            $display("FAIL fill_drain_count: got %0d want 9", obs_q.size() - base);
        end
        for (int k = 0; k < DEPTH + 1 && (base + k) < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[base + k] !== DW'(32'h200 + k)) begin
                n_bad++;
                $display("FAIL fill_order[%0d]: got %h want %h", k, obs_q[base + k], 32'h200 + k);
            end
        end
        n_cmp++;
        if (po_overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_sticky: got %b want 1", po_overflow);
        end
    endtask

    task automatic test_sticky_ack();
        bit seen;
        do_clear();
        n_cmp++;
        if (po_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_overflow: got %b want 0", po_overflow);
        end
        bus.pi_result_valid = 1'b1;
        bus.pi_result_data  = 32'h300;
        tick();
        bus.pi_result_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            tick();
            seen = (bus.po_write_to_fifo === 1'b1);
        end
        n_cmp++;
        if (!seen || bus.po_mlp_data !== 32'h300) begin
            n_bad++;
            $display("FAIL sticky_first_write: got seen=%0b data %h want 1 and 300", seen, bus.po_mlp_data);
        end
        ack_manual = 1'b1;
        tick();
        bus.pi_result_valid = 1'b1;
        bus.pi_result_data  = 32'h301;
        tick();
        bus.pi_result_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({po_word_count, bus.po_write_to_fifo, po_busy} !== {CW'(1), 2'b01}) begin
            n_bad++;
            $display("FAIL sticky_hold: count,write,busy got %0d,%b,%b want 1,0,1",
                     po_word_count, bus.po_write_to_fifo, po_busy);
        end
        ack_manual = 1'b0;
        tick();
        n_cmp++;
        if (bus.po_write_to_fifo !== 1'b0) begin
            n_bad++;
            $display("FAIL sticky_gap_exit: write got %b want 0", bus.po_write_to_fifo);
        end
        tick();
        n_cmp++;
        if ({bus.po_write_to_fifo, bus.po_mlp_data} !== {1'b1, 32'h301}) begin
            n_bad++;
            $display("FAIL sticky_next_write: write,data got %b,%h want 1,301",
                     bus.po_write_to_fifo, bus.po_mlp_data);
        end
        ack_manual = 1'b1;
        tick();
        ack_manual = 1'b0;
        tick();
        n_cmp++;
        if (po_word_count !== CW'(2)) begin
            n_bad++;
            $display("FAIL sticky_second_count: got %0d want 2", po_word_count);
        end
    endtask

    task automatic test_push_pop();
        int base, n;
        bit ok;
        do_clear();
        base = obs_q.size();
        for (int k = 0; k < 5; k++) begin
            bus.pi_result_valid = 1'b1;
            bus.pi_result_data  = 32'h400 + k;
            tick();
        end
        bus.pi_result_valid = 1'b0;
        ack_manual = 1'b1;
        tick();
        ack_manual = 1'b0;
        tick();
        bus.pi_result_valid = 1'b1;
        bus.pi_result_data  = 32'h405;
        tick();
        bus.pi_result_valid = 1'b0;
        n_cmp++;
        if ({bus.po_write_to_fifo, bus.po_mlp_data} !== {1'b1, 32'h401}) begin
            n_bad++;
            $display("FAIL pushpop_pop: write,data got %b,%h want 1,401", bus.po_write_to_fifo, bus.po_mlp_data);
        end
        n = 0;
        while (bus.po_result_ready === 1'b1 && n < 10) begin
            bus.pi_result_valid = 1'b1;
            bus.pi_result_data  = 32'h406 + n;
            tick();
            n++;
        end
        bus.pi_result_valid = 1'b0;
        n_cmp++;
        if (n != DEPTH - 4 || po_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL pushpop_occupancy: got %0d free slots overflow %b want 4 and 0", n, po_overflow);
        end
        ack_auto = 1'b1;
        wait_idle(base, 10, ok);
        n_cmp++;
        if (!ok || (obs_q.size() - base) != 10) begin
            n_bad++;
            $display("FAIL pushpop_drain_count: got %0d want 10", obs_q.size() - base);
        end
        for (int k = 0; k < 10 && (base + k) < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[base + k] !== DW'(32'h400 + k)) begin
                n_bad++;
                $display("FAIL pushpop_order[%0d]: got %h want %h", k, obs_q[base + k], 32'h400 + k);
            end
        end
    endtask

    task automatic test_mid_clear();
        int base;
        bit ok;
        do_clear();
        ack_auto = 1'b1;
        base = obs_q.size();
        for (int k = 0; k < 6; k++) begin
            bus.pi_result_valid = 1'b1;
            bus.pi_result_data  = 32'h500 + k;
            tick();
        end
        bus.pi_result_valid = 1'b0;
        wait_idle(base, 6, ok);
        ack_auto = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.pi_result_valid = 1'b1;
            bus.pi_result_data  = 32'h510 + k;
            tick();
        end
        bus.pi_result_valid = 1'b0;
        n_cmp++;
        if ({po_word_count, bus.po_write_to_fifo, bus.po_mlp_data} !== {CW'(6), 1'b1, 32'h510}) begin
            n_bad++;
            $display("FAIL midclear_setup: count,write,data got %0d,%b,%h want 6,1,510",
                     po_word_count, bus.po_write_to_fifo, bus.po_mlp_data);
        end
        pi_clear = 1'b1;
        tick();
        pi_clear = 1'b0;
        n_cmp++;
        if ({bus.po_write_to_fifo, po_word_count, po_busy, po_overflow, bus.po_result_ready} !==
            {1'b0, CW'(0), 3'b001}) begin
            n_bad++;
            $display("FAIL midclear_state: write,count,busy,ovf,ready got %b,%0d,%b,%b,%b want 0,0,0,0,1",
                     bus.po_write_to_fifo, po_word_count, po_busy, po_overflow, bus.po_result_ready);
        end
        base = obs_q.size();
        ack_auto = 1'b1;
        repeat (30) tick();
        n_cmp++;
        if (obs_q.size() != base || po_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midclear_no_stale: got %0d writes busy %b want 0 and 0", obs_q.size() - base, po_busy);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] d;
        int base, fdb, stb;
        bit v, ovf_exp, ok;
        do_clear();
        ack_auto = 1'b1;
        base = obs_q.size(); fdb = fd_cnt; stb = stab_err;
        ovf_exp = 1'b0;
        for (int c = 0; c < 150; c++) begin
            v = ($urandom_range(0, 1) == 1);
            d = $urandom;
            bus.pi_result_valid = v;
            bus.pi_result_data  = d;
            if (v && bus.po_result_ready === 1'b1) exp_q.push_back(d);
            if (v && bus.po_result_ready === 1'b0) ovf_exp = 1'b1;
            tick();
        end
        bus.pi_result_valid = 1'b0;
        wait_idle(base, exp_q.size(), ok);
        n_cmp++;
        if (!ok || (obs_q.size() - base) != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: got %0d want %0d", obs_q.size() - base, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && (base + k) < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[base + k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL random_order[%0d]: got %h want %h", k, obs_q[base + k], exp_q[k]);
            end
        end
        n_cmp++;
        if ((fd_cnt - fdb) != exp_q.size() / FLEN || po_word_count !== CW'(exp_q.size() % FLEN)) begin
            n_bad++;
            $display("FAIL random_frames: got %0d pulses count %0d want %0d and %0d",
                     fd_cnt - fdb, po_word_count, exp_q.size() / FLEN, exp_q.size() % FLEN);
        end
        n_cmp++;
        if (po_overflow !== ovf_exp || stab_err != stb) begin
            n_bad++;
            $display("FAIL random_overflow: got %b unstable %0d want %b and 0", po_overflow, stab_err - stb, ovf_exp);
        end
    endtask

    initial begin
        bus.pi_result_valid = 1'b0;
        bus.pi_result_data  = '0;
        test_reset();
        test_burst();
        test_fill_overflow();
        test_sticky_ack();
        test_push_pop();
        test_mid_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mlp_result_drain.md
Name: mlp_result_drain

Overview:
- Collects result words from the MLP output layer into a small FIFO.
- Feeds them one at a time into the AXI-Stream master's write port using the pi_mlp_data / pi_write_to_fifo / po_wr_fifo_done handshake.
- Counts completed hand-offs per output frame and pulses a frame-done flag.
- Sits directly upstream of the AXI-Stream master, between the MLP datapath and the DMA-facing stream.

Parameters:
- DATA_WIDTH, 32, width of result words. Must equal the AXI-Stream master's C_M_AXIS_TDATA_WIDTH.
- FIFO_DEPTH, 8, entries in the internal buffer. Power of two, minimum 2.
- FRAME_LEN, 10, words per output frame (one per output neuron). Minimum 1.

Ports:
- ACLK  in  1  clock; everything is synchronous to its rising edge
- ARESET  in  1  synchronous, active-high reset
- pi_clear  in  1  synchronous flush; same effect as ARESET
- pi_result_data  in  DATA_WIDTH  result word from the MLP
- pi_result_valid  in  1  pi_result_data is valid this cycle
- po_result_ready  out  1  FIFO can accept a word this cycle
- po_mlp_data  out  DATA_WIDTH  word presented to the AXI-Stream master
- po_write_to_fifo  out  1  write request to the AXI-Stream master
- pi_wr_fifo_done  in  1  level acknowledge from the AXI-Stream master
- po_frame_done  out  1  one-cycle pulse when FRAME_LEN words have been handed off
- po_word_count  out  $clog2(FRAME_LEN+1)  words handed off in the current frame
- po_overflow  out  1  sticky; a word arrived while the FIFO was full
- po_busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset and clear (ARESET or pi_clear high at a rising edge):
  - FIFO emptied, pointers zeroed.
  - FSM goes to IDLE.
  - Outputs: po_mlp_data=0, po_write_to_fifo=0, po_frame_done=0, po_word_count=0, po_overflow=0, po_busy=0, po_result_ready=1 from the next cycle.
  - Reset/clear wins over every other event in the same cycle, including a handshake in progress; the word being held is discarded.
- Ingress:
  - po_result_ready = !full. It is decoded from the registered occupancy only; there is no same-cycle bypass.
  - A word is pushed when pi_result_valid && po_result_ready at the edge.
  - If pi_result_valid is high while full: the word is dropped, po_overflow is set and stays set until reset/clear, and FIFO contents are unchanged.
  - A push and a pop in the same edge are legal; occupancy stays the same.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
- FSM states: IDLE, WRITE, GAP.
  - IDLE: if the FIFO is non-empty, pop the head into po_mlp_data, set po_write_to_fifo=1 and go to WRITE, all at the same edge. Otherwise stay.
  - WRITE:
    - Hold po_mlp_data stable and po_write_to_fifo=1.
    - When pi_wr_fifo_done is sampled high: drive po_write_to_fifo=0, increment po_word_count, go to GAP.
    - No timeout; the FSM waits indefinitely for the acknowledge.
  - GAP:
    - Stay while pi_wr_fifo_done=1. This is required because the acknowledge is level and must not be double-counted.
    - Return to IDLE when pi_wr_fifo_done=0. The next pop can happen no earlier than the edge after that.
- Latency: a word accepted into an empty FIFO in IDLE at edge N has po_write_to_fifo=1 and the word on po_mlp_data from edge N+1.
- Minimum per-word period: 3 cycles (IDLE→WRITE→GAP→IDLE) with a one-cycle acknowledge.
- Frame counting:
  - On the increment that makes the count reach FRAME_LEN, po_word_count goes to 0 instead.
  - po_frame_done is high for exactly that one cycle (registered, aligned with the count reset).
  - FRAME_LEN=1: po_frame_done pulses after every word.
- po_busy is registered: (occupancy != 0) || (state != IDLE).
- pi_wr_fifo_done high while in IDLE is ignored.

Test Plan:
- Reset: hold ARESET for 3 cycles with pi_result_valid=1 → all outputs 0, po_result_ready=1, nothing pushed. Release; push 0xA5A5_0001 → po_write_to_fifo=1 with po_mlp_data=0xA5A5_0001 exactly one cycle later.
- Burst of 10 words 0x100..0x109 with the acknowledge modelled as the AXI-Stream master (done after a random 1–10 cycles, dropped after write falls):
  - required: 10 write requests in order, each word stable while write is high, no duplicates;
  - po_frame_done pulses once after word 0x109, and po_word_count returns to 0.
- Fill and overflow: acknowledge held low, push 12 words → po_result_ready=0 after 9 accepted (1 held in WRITE + 8 buffered), 3 dropped, po_overflow=1. Then release the acknowledge → exactly 9 words emerge, in order.
- Sticky acknowledge: hold pi_wr_fifo_done high for 5 cycles after one write → po_word_count increments by exactly 1 and the FSM stays in GAP until done falls.
- Simultaneous push and pop at occupancy 4 → occupancy stays 4, ordering preserved, no overflow.
- Mid-frame clear: pulse pi_clear while in WRITE with 3 words buffered and po_word_count=6 → next cycle po_write_to_fifo=0, po_word_count=0, po_busy=0, po_overflow=0, and no stale word is emitted afterwards.
